// File: rtl/enc4to2_reg_if.sv
`default_nettype none
// ============================================================================
//  Module      : enc4to2_reg_if
//  Description : Valid/ready bus for the registered 4-to-2 one-hot encoder.
//                The master modport is the producer/consumer side and the
//                slave modport is the encoder itself.
//  Revision    : 1.0 - initial release
// ============================================================================
interface enc4to2_reg_if #(
    parameter int CNT_W = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [3:0]       Y;
    logic             out_valid;
    logic             out_ready;
    logic             A;
    logic             B;
    logic             err;
    logic [CNT_W-1:0] err_cnt;

    modport master (
        output in_valid,
        output Y,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  A,
        input  B,
        input  err,
        input  err_cnt
    );

    modport slave (
        input  in_valid,
        input  Y,
        input  out_ready,
        output in_ready,
        output out_valid,
        output A,
        output B,
        output err,
        output err_cnt
    );
endinterface
`default_nettype wire

// File: rtl/enc4to2_reg.sv
`default_nettype none
// ============================================================================
//  Module      : enc4to2_reg
//  Description : Registered 4-to-2 one-hot encoder with a single-entry
//                valid/ready output register, an error flag for
//                non-one-hot codes (priority-encoded on the highest set bit)
//                and a saturating count of accepted erroneous codes.
//  Revision    : 1.0 - initial release
// ============================================================================
module enc4to2_reg #(
    parameter int CNT_W = 8
) (
    input  wire logic     clk,
    input  wire logic     rst_n,
    enc4to2_reg_if.slave  bus
);

    typedef enum logic [0:0] {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } state_t;

    state_t           r_state;
    logic             r_a;
    logic             r_b;
    logic             r_err;
    logic [CNT_W-1:0] r_err_cnt;

    logic             w_accept;
    logic             w_a;
    logic             w_b;
    logic             w_err;
    logic             w_cnt_max;

    // The slot can take a new code when empty or when the current result
    // leaves in this same cycle; this keeps full throughput under out_ready.
    assign bus.in_ready = (r_state == ST_EMPTY) || bus.out_ready;
    assign w_accept     = bus.in_valid && bus.in_ready;
    assign w_cnt_max    = &r_err_cnt;

    // Priority encode on the highest set bit; flag anything not exactly one-hot.
    always_comb begin
        w_a   = 1'b0;
        w_b   = 1'b0;
        w_err = 1'b1;
        casez (bus.Y)
            4'b1???: {w_a, w_b} = 2'b11;
            4'b01??: {w_a, w_b} = 2'b10;
            4'b001?: {w_a, w_b} = 2'b01;
            default: {w_a, w_b} = 2'b00;
        endcase
        if ((bus.Y == 4'b0001) || (bus.Y == 4'b0010) ||
            (bus.Y == 4'b0100) || (bus.Y == 4'b1000)) begin
            w_err = 1'b0;
        end
    end

    // Handshake state, result register and saturating error counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_EMPTY;
            r_a       <= 1'b0;
            r_b       <= 1'b0;
            r_err     <= 1'b0;
            r_err_cnt <= '0;
        end else begin
            case (r_state)
                ST_EMPTY: begin
                    if (w_accept) begin
                        r_state <= ST_FULL;
                    end
                end
                ST_FULL: begin
                    if (bus.out_ready && !w_accept) begin
                        r_state <= ST_EMPTY;
                    end
                end
                default: r_state <= ST_EMPTY;
            endcase

            // Result only moves on accept, so it holds under back-pressure
            // and keeps its last value after a drain.
            if (w_accept) begin
                r_a   <= w_a;
                r_b   <= w_b;
                r_err <= w_err;
            end

            if (w_accept && w_err && !w_cnt_max) begin
                r_err_cnt <= r_err_cnt + 1'b1;
            end
        end
    end

    assign bus.out_valid = (r_state == ST_FULL);
    assign bus.A         = r_a;
    assign bus.B         = r_b;
    assign bus.err       = r_err;
    assign bus.err_cnt   = r_err_cnt;

endmodule
`default_nettype wire

// File: tb/tb_enc4to2_reg.sv
`default_nettype none
// ============================================================================
//  Module      : tb_enc4to2_reg
//  Description : Self-checking bench for enc4to2_reg. A behavioural model
//                (bit-scan encoder, popcount error rule, one-slot buffer)
//                tracks the expected outputs; a second instance with a
//                2-bit counter covers saturation.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_enc4to2_reg;

    localparam int CNT_W   = 8;
    localparam int CNT_W2  = 2;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic clk;
    logic rst_n;

    enc4to2_reg_if #(.CNT_W(CNT_W))  bus  ();
    enc4to2_reg_if #(.CNT_W(CNT_W2)) bus2 ();

    enc4to2_reg #(.CNT_W(CNT_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    enc4to2_reg #(.CNT_W(CNT_W2)) dut2 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus2.slave)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state
    logic       m_valid;
    logic [1:0] m_ab;
    logic       m_err;
    int         m_cnt;

    // Values driven for the upcoming edge
    logic       d_v;
    logic [3:0] d_y;
    logic       d_r;

    // {index of highest set bit, not-exactly-one-hot}
    function automatic logic [2:0] ref_enc(input logic [3:0] y);
        int idx = 0;
        for (int i = 0; i < 4; i++) begin
            if (y[i]) idx = i;
        end
        return {idx[1:0], ($countones(y) != 1)};
    endfunction

    function automatic logic m_ready();
        return !m_valid || d_r;
    endfunction

    task automatic model_reset();
        m_valid = 1'b0;
        m_ab    = 2'b00;
        m_err   = 1'b0;
        m_cnt   = 0;
    endtask

    task automatic drive(input logic v, input logic [3:0] y, input logic r);
        @(negedge clk);
        d_v = v;
        d_y = y;
        d_r = r;
        bus.in_valid  = v;
        bus.Y         = v ? y : 4'bxxxx;
        bus.out_ready = r;
        #1;
    endtask

    // One clock edge; the model advances with the values that were driven.
    task automatic step();
        logic [2:0] e;
        @(posedge clk);
        if (d_v && m_ready()) begin
            e       = ref_enc(d_y);
            m_ab    = e[2:1];
            m_err   = e[0];
            m_valid = 1'b1;
            if (e[0] && m_cnt < CNT_MAX) m_cnt++;
        end else if (d_r) begin
            m_valid = 1'b0;
        end
        #1;
    endtask

    task automatic test_reset();
        rst_n          = 1'b0;
        bus.in_valid   = 1'($urandom);
        bus.Y          = 4'($urandom);
        bus.out_ready  = 1'($urandom);
        bus2.in_valid  = 1'b1;
        bus2.Y         = 4'($urandom);
        bus2.out_ready = 1'b0;
        model_reset();
        // Check before and after an edge with reset held
        for (int k = 0; k < 2; k++) begin
            if (k == 0) #3; else begin @(posedge clk); #1; end
            n_checks++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b want 0", bus.out_valid); end
            n_checks++; if ({bus.A, bus.B} !== 2'b00) begin n_fail++; $display("FAIL reset_ab: got %b want 00", {bus.A, bus.B}); end
            n_checks++; if (bus.err !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b want 0", bus.err); end
            n_checks++; if (bus.err_cnt !== 8'd0) begin n_fail++; $display("FAIL reset_err_cnt: got %0d want 0", bus.err_cnt); end
            n_checks++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b want 1", bus.in_ready); end
            n_checks++; if (bus2.out_valid !== 1'b0 || bus2.err_cnt !== 2'd0) begin n_fail++; $display("FAIL reset_dut2: got valid=%b cnt=%0d want 0/0", bus2.out_valid, bus2.err_cnt); end
        end
        bus2.in_valid = 1'b0;
        drive(1'b0, 4'b0000, 1'b1);
        rst_n = 1'b1;
    endtask

    task automatic test_code_sweep();
        logic [3:0] ys [4]  = '{4'b0001, 4'b0100, 4'b1000, 4'b0010};
        logic [1:0] abs [4] = '{2'b00, 2'b10, 2'b11, 2'b01};
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, ys[i], 1'b1);
            n_checks++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL sweep_in_ready[%0d]: got %b want 1", i, bus.in_ready); end
            step();
            n_checks++; if (bus.out_valid !== 1'b1) begin n_fail++; $display("FAIL sweep_out_valid[%0d]: got %b want 1", i, bus.out_valid); end
            n_checks++; if ({bus.A, bus.B} !== abs[i]) begin n_fail++; $display("FAIL sweep_ab[%0d]: got %b want %b", i, {bus.A, bus.B}, abs[i]); end
            n_checks++; if (bus.err !== 1'b0) begin n_fail++; $display("FAIL sweep_err[%0d]: got %b want 0", i, bus.err); end
        end
    endtask

    task automatic test_error_codes();
        logic [3:0] ys [3]  = '{4'b0000, 4'b0110, 4'b1111};
        logic [1:0] abs [3] = '{2'b00, 2'b10, 2'b11};
        int base = m_cnt;
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, ys[i], 1'b1);
            step();
            n_checks++; if ({bus.A, bus.B} !== abs[i] || bus.err !== 1'b1) begin n_fail++; $display("FAIL errcode_ab_err[%0d]: got %b/%b want %b/1", i, {bus.A, bus.B}, bus.err, abs[i]); end
            n_checks++; if (int'(bus.err_cnt) !== base + i + 1) begin n_fail++; $display("FAIL errcode_cnt[%0d]: got %0d want %0d", i, bus.err_cnt, base + i + 1); end
        end
        n_checks++; if (bus.err_cnt !== 8'd3) begin n_fail++; $display("FAIL errcode_total: got %0d want 3", bus.err_cnt); end
    endtask

    task automatic test_back_pressure();
        drive(1'b1, 4'b0100, 1'b1);
        step();
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 4'b1000, 1'b0);
            n_checks++; if (bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_in_ready[%0d]: got %b want 0", i, bus.in_ready); end
            step();
            n_checks++; if (bus.out_valid !== 1'b1 || {bus.A, bus.B} !== 2'b10) begin n_fail++; $display("FAIL bp_hold[%0d]: got valid=%b ab=%b want 1/10", i, bus.out_valid, {bus.A, bus.B}); end
        end
        drive(1'b1, 4'b1000, 1'b1);
        n_checks++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_release_ready: got %b want 1", bus.in_ready); end
        step();
        n_checks++; if (bus.out_valid !== 1'b1 || {bus.A, bus.B} !== 2'b11) begin n_fail++; $display("FAIL bp_next: got valid=%b ab=%b want 1/11", bus.out_valid, {bus.A, bus.B}); end
        drive(1'b0, 4'b0000, 1'b1);
        step();
        n_checks++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL bp_drain: got %b want 0", bus.out_valid); end
    endtask

    task automatic test_random();
        for (int i = 0; i < 300; i++) begin
            drive(1'($urandom_range(0, 3) != 0), 4'($urandom), 1'($urandom_range(0, 2) != 0));
            n_checks++; if (bus.in_ready !== m_ready()) begin n_fail++; $display("FAIL rand_in_ready[%0d]: got %b want %b", i, bus.in_ready, m_ready()); end
            step();
            n_checks++; if (bus.out_valid !== m_valid) begin n_fail++; $display("FAIL rand_out_valid[%0d]: got %b want %b", i, bus.out_valid, m_valid); end
            if (m_valid) begin
                n_checks++; if ({bus.A, bus.B, bus.err} !== {m_ab, m_err}) begin n_fail++; $display("FAIL rand_result[%0d]: got ab=%b err=%b want ab=%b err=%b", i, {bus.A, bus.B}, bus.err, m_ab, m_err); end
            end
            n_checks++; if (int'(bus.err_cnt) !== m_cnt) begin n_fail++; $display("FAIL rand_err_cnt[%0d]: got %0d want %0d", i, bus.err_cnt, m_cnt); end
        end
        drive(1'b0, 4'b0000, 1'b1);
        step();
    endtask

    task automatic test_saturation();
        int exp_cnt [5] = '{1, 2, 3, 3, 3};
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            bus2.in_valid  = 1'b1;
            bus2.Y         = 4'b0011;
            bus2.out_ready = 1'b1;
            @(posedge clk);
            #1;
            n_checks++; if (int'(bus2.err_cnt) !== exp_cnt[i]) begin n_fail++; $display("FAIL sat_cnt[%0d]: got %0d want %0d", i, bus2.err_cnt, exp_cnt[i]); end
            n_checks++; if ({bus2.A, bus2.B, bus2.err} !== 3'b011) begin n_fail++; $display("FAIL sat_result[%0d]: got %b want 011", i, {bus2.A, bus2.B, bus2.err}); end
        end
        @(negedge clk);
        bus2.in_valid = 1'b0;
    endtask

    task automatic test_mid_reset();
        // Fresh counter, then two error accepts and a stall
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        rst_n = 1'b1;
        model_reset();
        drive(1'b1, 4'b0000, 1'b1);
        step();
        drive(1'b1, 4'b0110, 1'b1);
        step();
        drive(1'b0, 4'b0000, 1'b0);
        step();
        n_checks++; if (bus.out_valid !== 1'b1 || bus.err_cnt !== 8'd2) begin n_fail++; $display("FAIL midrst_setup: got valid=%b cnt=%0d want 1/2", bus.out_valid, bus.err_cnt); end
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL midrst_out_valid: got %b want 0", bus.out_valid); end
        n_checks++; if (bus.err_cnt !== 8'd0) begin n_fail++; $display("FAIL midrst_err_cnt: got %0d want 0", bus.err_cnt); end
        n_checks++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL midrst_in_ready: got %b want 1", bus.in_ready); end
        #1;
        rst_n = 1'b1;
        model_reset();
        drive(1'b1, 4'b0001, 1'b1);
        step();
        n_checks++; if (bus.out_valid !== 1'b1 || {bus.A, bus.B, bus.err} !== 3'b000) begin n_fail++; $display("FAIL midrst_first: got valid=%b ab_err=%b want 1/000", bus.out_valid, {bus.A, bus.B, bus.err}); end
        n_checks++; if (bus.err_cnt !== 8'd0) begin n_fail++; $display("FAIL midrst_first_cnt: got %0d want 0", bus.err_cnt); end
    endtask

    initial begin
        d_v = 1'b0;
        d_y = 4'b0000;
        d_r = 1'b1;
        test_reset();
        test_code_sweep();
        test_error_codes();
        test_back_pressure();
        test_random();
        test_saturation();
        test_mid_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
